// File: rtl/vslc_scan_if.sv
// Pin-level bundle between the vslc scan sequencer and its surroundings.
// master: the sequencer (drives pc/strobes/status); slave: pins and core.
`timescale 1ns/1ps
interface vslc_scan_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              ena;
  logic              run;
  logic              step;
  logic              halt_req;
  logic              clr_fault;
  logic [ADDR_W-1:0] pc;
  logic              addr_strobe;
  logic              in_latch;
  logic              out_commit;
  logic              scan_cycle_clk;
  logic              busy;
  logic              overrun;

  modport master (
    input  ena, run, step, halt_req, clr_fault,
    output pc, addr_strobe, in_latch, out_commit, scan_cycle_clk, busy, overrun
  );

  modport slave (
    output ena, run, step, halt_req, clr_fault,
    input  pc, addr_strobe, in_latch, out_commit, scan_cycle_clk, busy, overrun
  );
endinterface

// File: rtl/vslc_scan_sequencer.sv
// PLC scan-loop sequencer: latch inputs, step pc through the program, commit, pad to period.
// Define VSLC_OVERRUN_EN to build the sticky overrun flag and clr_fault.
`timescale 1ns/1ps
module vslc_scan_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned PROG_LEN    = 32,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned SCAN_PERIOD = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  vslc_scan_if.master  bus
);

  localparam logic [ADDR_W-1:0]   PC_LAST = ADDR_W'(PROG_LEN - 1);
  localparam logic [PERIOD_W-1:0] T_LAST  = PERIOD_W'(SCAN_PERIOD - 1);
  localparam logic [PERIOD_W-1:0] T_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_EXEC,
    S_COMMIT,
    S_WAIT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] timer_nxt;
  logic                sclk_q;
  logic                sclk_nxt;
  logic                in_latch_q;
  logic                addr_strobe_q;
  logic                out_commit_q;
  logic                busy_q;
  logic                late_c;

  assign late_c = (timer >= T_LAST);

  // State, counters and Moore outputs; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc_q          <= '0;
      timer         <= '0;
      sclk_q        <= 1'b0;
      in_latch_q    <= 1'b0;
      addr_strobe_q <= 1'b0;
      out_commit_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else if (bus.ena) begin
      state         <= state_nxt;
      pc_q          <= pc_nxt;
      timer         <= timer_nxt;
      sclk_q        <= sclk_nxt;
      in_latch_q    <= (state_nxt == S_LATCH);
      addr_strobe_q <= (state_nxt == S_EXEC);
      out_commit_q  <= (state_nxt == S_COMMIT);
      busy_q        <= (state_nxt != S_IDLE);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    timer_nxt = timer;
    sclk_nxt  = sclk_q;

    if (timer != T_MAX) begin
      timer_nxt = timer + PERIOD_W'(1);
    end

    case (state)
      S_IDLE: begin
        timer_nxt = timer;
        if (bus.run || bus.step) begin
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if ((pc_q == PC_LAST) || bus.halt_req) begin
          state_nxt = S_COMMIT;
        end else begin
          pc_nxt = pc_q + ADDR_W'(1);
        end
      end
      S_COMMIT: begin
        sclk_nxt = ~sclk_q;
        if (late_c) begin
          state_nxt = bus.run ? S_LATCH : S_IDLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timer == T_LAST) begin
          state_nxt = bus.run ? S_LATCH : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Each scan restarts the program and the period timer.
    if (state_nxt == S_LATCH) begin
      pc_nxt    = '0;
      timer_nxt = '0;
    end
  end

`ifdef VSLC_OVERRUN_EN
  logic overrun_q;
  logic overdue_c;

  assign overdue_c = (timer > T_LAST);

  // Sticky late-scan flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (bus.ena) begin
      if ((state == S_COMMIT) && overdue_c) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_fault) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.overrun = overrun_q;
`else
  logic unused_clr_fault;
  assign unused_clr_fault = bus.clr_fault;
  assign bus.overrun      = 1'b0;
`endif

  assign bus.pc             = pc_q;
  assign bus.addr_strobe    = addr_strobe_q;
  assign bus.in_latch       = in_latch_q;
  assign bus.out_commit     = out_commit_q;
  assign bus.scan_cycle_clk = sclk_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Scoreboard bench for vslc_scan_sequencer (PROG_LEN=8, periods 16 and 8).
`timescale 1ns/1ps
module tb_vslc_scan_sequencer;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PROG_LEN = 8;
  localparam int unsigned PERIOD_W = 16;
`ifdef VSLC_OVERRUN_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  localparam int K_LATCH  = 0;
  localparam int K_STROBE = 1;
  localparam int K_COMMIT = 2;

  typedef struct {
    int   kind;
    int   pc;
    int   gap;
    logic sclk;
  } ev_t;

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst_n;
  logic halt_en;
  logic [ADDR_W-1:0] halt_pc;

  int checks   = 0;
  int failures = 0;
  int cyc        = 0;
  int last_latch = 0;
  bit en_prev    = 1'b1;
  ev_t exp_q[$];

  always #5 if (clk_run) clk = ~clk;

  vslc_scan_if #(.ADDR_W(ADDR_W)) bus ();
  vslc_scan_if #(.ADDR_W(ADDR_W)) bus2 ();

  // Core model: END instruction when the chosen pc is being executed.
  assign bus.halt_req = halt_en && bus.addr_strobe && (bus.pc == halt_pc);

  vslc_scan_sequencer #(
    .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .PERIOD_W(PERIOD_W), .SCAN_PERIOD(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  vslc_scan_sequencer #(
    .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .PERIOD_W(PERIOD_W), .SCAN_PERIOD(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_scan(input int n, input int gap, input logic sclk);
    exp_q.push_back('{kind: K_LATCH, pc: 0, gap: gap, sclk: 1'b0});
    for (int i = 0; i < n; i++) exp_q.push_back('{kind: K_STROBE, pc: i, gap: 0, sclk: 1'b0});
    exp_q.push_back('{kind: K_COMMIT, pc: 0, gap: 0, sclk: sclk});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      tick(1);
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic wait_strobe(input int p);
    int n = 0;
    while (!(bus.addr_strobe && bus.pc == ADDR_W'(p)) && n < 100) begin
      tick(1);
      n++;
    end
    check("wait_strobe_pc", bus.addr_strobe && bus.pc == ADDR_W'(p), 1);
  endtask

  task automatic wait_latch2(output int t);
    int n = 0;
    tick(1);
    while (!bus2.in_latch && n < 100) begin
      tick(1);
      n++;
    end
    check("dut2_latch_seen", bus2.in_latch, 1);
    t = cyc;
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_prev <= bus.ena;
  end

  // Monitor: each enabled cycle with a pulse/strobe consumes one expected event.
  always @(negedge clk) begin
    ev_t e;
    int  act_kind;
    if (rst_n && en_prev && (bus.in_latch || bus.addr_strobe || bus.out_commit)) begin
      act_kind = bus.in_latch ? K_LATCH : (bus.addr_strobe ? K_STROBE : K_COMMIT);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got event kind %0d pc %0d, required none", act_kind, bus.pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", act_kind, e.kind);
        check("sb_single", 32'(bus.in_latch) + 32'(bus.addr_strobe) + 32'(bus.out_commit), 1);
        if (e.kind == K_STROBE) check("sb_pc", bus.pc, e.pc);
        if (e.kind == K_COMMIT) check("sb_sclk", bus.scan_cycle_clk, e.sclk);
        if (e.kind == K_LATCH) begin
          if (e.gap != 0) check("sb_period", cyc - last_latch, e.gap);
          last_latch = cyc;
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, n;
    rst_n = 1'b1;
    halt_en = 1'b0;
    halt_pc = '0;
    bus.ena = 1'b1;  bus.run = 1'b0;  bus.step = 1'b0;  bus.clr_fault = 1'b0;
    bus2.ena = 1'b1; bus2.run = 1'b0; bus2.step = 1'b0; bus2.clr_fault = 1'b0;
    bus2.halt_req = 1'b0;

    // Asynchronous reset with the clock stopped.
    #5 rst_n = 1'b0;
    #1;
    check("rst_pc", bus.pc, 0);
    check("rst_strobe", bus.addr_strobe, 0);
    check("rst_in_latch", bus.in_latch, 0);
    check("rst_out_commit", bus.out_commit, 0);
    check("rst_sclk", bus.scan_cycle_clk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst2_busy", bus2.busy, 0);
    clk_run = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Continuous run: two full scans, period 16.
    push_scan(8, 0, 1'b0);
    push_scan(8, 16, 1'b1);
    bus.run = 1'b1;
    tick(20);
    bus.run = 1'b0;
    wait_idle("a_idle");
    check("a_sclk", bus.scan_cycle_clk, 0);

    // END at pc=3: four strobes, period unchanged.
    halt_pc = ADDR_W'(3);
    halt_en = 1'b1;
    push_scan(4, 0, 1'b0);
    push_scan(4, 16, 1'b1);
    bus.run = 1'b1;
    tick(20);
    bus.run = 1'b0;
    wait_idle("b_idle");
    halt_en = 1'b0;

    // Single-step pulse: exactly one scan.
    push_scan(8, 0, 1'b0);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    wait_idle("c_idle");
    check("c_sclk", bus.scan_cycle_clk, 1);
    tick(20);
    check("c_no_repeat", bus.busy, 0);

    // Reset at pc=5, then release with run held.
    exp_q.push_back('{kind: K_LATCH, pc: 0, gap: 0, sclk: 1'b0});
    for (int i = 0; i < 5; i++) exp_q.push_back('{kind: K_STROBE, pc: i, gap: 0, sclk: 1'b0});
    bus.run = 1'b1;
    wait_strobe(5);
    rst_n = 1'b0;
    #1;
    check("d_rst_pc", bus.pc, 0);
    check("d_rst_strobe", bus.addr_strobe, 0);
    check("d_rst_sclk", bus.scan_cycle_clk, 0);
    check("d_rst_busy", bus.busy, 0);
    push_scan(8, 0, 1'b0);
    push_scan(8, 16, 1'b1);
    push_scan(8, 19, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    check("d_latch_after_release", bus.in_latch, 1);
    // Freeze three cycles inside the second scan's EXEC.
    tick(19);
    check("d_in_exec", bus.addr_strobe, 1);
    bus.ena = 1'b0;
    tick(3);
    bus.ena = 1'b1;
    tick(20);
    bus.run = 1'b0;
    wait_idle("d_idle");
    check("d_sclk", bus.scan_cycle_clk, 1);
    check("d_overrun", bus.overrun, 0);

    // Late scans on the SCAN_PERIOD=8 instance.
    bus2.run = 1'b1;
    wait_latch2(t0);
    wait_latch2(t1);
    check("e_period1", t1 - t0, 10);
    check("e_overrun_set", bus2.overrun, OV_EN);
    bus2.clr_fault = 1'b1;
    tick(1);
    bus2.clr_fault = 1'b0;
    check("e_overrun_clr", bus2.overrun, 0);
    wait_latch2(t2);
    check("e_period2", t2 - t1, 10);
    check("e_overrun_reset", bus2.overrun, OV_EN);
    bus2.clr_fault = 1'b1;
    wait_latch2(t3);
    check("e_period3", t3 - t2, 10);
    check("e_set_wins", bus2.overrun, OV_EN);
    bus2.clr_fault = 1'b0;
    bus2.run = 1'b0;
    n = 0;
    while (bus2.busy && n < 100) begin
      tick(1);
      n++;
    end
    check("e_idle", bus2.busy, 0);

    tick(5);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
